// File: rtl/axi_burst_addr_gen.sv
// Per-beat address / byte-strobe generator for AXI4 AW/AR bursts (FIXED, INCR, WRAP).
// Define AXI_BURST_LEGALITY_CHECK_EN to flag illegal requests on err_o; otherwise err_o is tied low.
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ID_WIDTH-1:0]     req_id_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [7:0]              req_len_i,
    input  logic [2:0]              req_size_i,
    input  logic [1:0]              req_burst_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ID_WIDTH-1:0]     beat_id_o,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic [7:0]              beat_idx_o,
    output logic                    beat_last_o,
    output logic                    err_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   addr_nxt_s;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [7:0]              idx_q, idx_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;

    // Lanes from the (possibly unaligned) byte offset up to the end of its 2^size container.
    function automatic logic [STRB_W-1:0] strb_calc(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [2:0] sz);
        int unsigned lo;
        int unsigned hi;
        int unsigned bsz;
        logic [STRB_W-1:0] m;
        bsz = 32'd1 << sz;
        lo  = 32'(a[OFF_W-1:0]) % 32'(STRB_W);
        hi  = (lo & ~(bsz - 32'd1)) + bsz;
        for (int i = 0; i < STRB_W; i++) begin
            m[i] = (32'(i) >= lo) && (32'(i) < hi);
        end
        return m;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] cur,
                                                        input logic [ADDR_WIDTH-1:0] start,
                                                        input logic [7:0] len,
                                                        input logic [2:0] sz,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] w;
        logic [ADDR_WIDTH-1:0] lower;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] nxt;
        b     = ADDR_WIDTH'(1'b1) << sz;
        w     = ADDR_WIDTH'({1'b0, len} + 9'd1) << sz;
        lower = start & ~(w - ADDR_WIDTH'(1'b1));
        inc   = (cur & ~(b - ADDR_WIDTH'(1'b1))) + b;
        case (burst)
            2'b00:   nxt = cur;
            2'b10:   nxt = (inc == lower + w) ? lower : inc;
            default: nxt = inc;
        endcase
        return nxt;
    endfunction

`ifdef AXI_BURST_LEGALITY_CHECK_EN
    function automatic logic illegal_req(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [7:0] len,
                                         input logic [2:0] sz,
                                         input logic [1:0] burst);
        logic [11:0] mask12;
        logic [16:0] last_byte;
        logic        wrap_len_bad;
        mask12       = (12'd1 << sz) - 12'd1;
        last_byte    = 17'(a[11:0] & ~mask12) + (17'({1'b0, len} + 9'd1) << sz) - 17'd1;
        wrap_len_bad = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return ((burst == 2'b10) && wrap_len_bad) ||
               ((burst == 2'b10) && ((a[11:0] & mask12) != 12'd0)) ||
               ((burst == 2'b01) && (last_byte[16:12] != 5'd0)) ||
               (32'(sz) > 32'($clog2(STRB_W))) ||
               (burst == 2'b11);
    endfunction
`endif

    // Next-state and next-output logic for the IDLE/BURST sequencer.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        last_d     = last_q;
        err_d      = 1'b0;
        id_d       = id_q;
        addr_d     = addr_q;
        start_d    = start_q;
        strb_d     = strb_q;
        idx_d      = idx_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        addr_nxt_s = next_addr(addr_q, start_q, len_q, size_q, burst_q);
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = BURST;
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    id_d    = req_id_i;
                    addr_d  = req_addr_i;
                    start_d = req_addr_i;
                    len_d   = req_len_i;
                    size_d  = req_size_i;
                    burst_d = req_burst_i;
                    idx_d   = 8'd0;
                    last_d  = (req_len_i == 8'd0);
                    strb_d  = strb_calc(req_addr_i, req_size_i);
`ifdef AXI_BURST_LEGALITY_CHECK_EN
                    err_d   = illegal_req(req_addr_i, req_len_i, req_size_i, req_burst_i);
`else
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (beat_ready_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        addr_d = addr_nxt_s;
                        strb_d = strb_calc(addr_nxt_s, size_q);
                        last_d = ((idx_q + 8'd1) == len_q);
                    end
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            start_q <= '0;
            strb_q  <= '0;
            idx_q   <= 8'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            strb_q  <= strb_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign beat_valid_o = valid_q;
    assign beat_id_o    = id_q;
    assign beat_addr_o  = addr_q;
    assign beat_strb_o  = strb_q;
    assign beat_idx_o   = idx_q;
    assign beat_last_o  = last_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed bursts plus randomized bursts
// checked against a closed-form address/strobe model.
module tb_axi_burst_addr_gen;
`ifdef AXI_BURST_LEGALITY_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_id, beat_id;
    logic [31:0] req_addr, beat_addr;
    logic [7:0]  req_len, beat_idx;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        beat_valid, beat_ready, beat_last, err;
    logic [7:0]  beat_strb;

    int total = 0;
    int bad   = 0;

    logic [31:0] o_addr[$];
    logic [7:0]  o_strb[$];
    logic [7:0]  o_idx[$];
    logic        o_last[$];
    logic [3:0]  o_id[$];
    int          o_err_cnt, o_hold_viol, o_busy_ready;
    logic        o_err_first, o_first_valid, o_ready_after, o_valid_after;
    bit          o_timeout;
    logic        r_pat[$];
    int          rdy_pct = 100;

    always #5 clk = ~clk;

    axi_burst_addr_gen dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size), .req_burst_i(req_burst),
        .beat_valid_o(beat_valid), .beat_ready_i(beat_ready), .beat_id_o(beat_id),
        .beat_addr_o(beat_addr), .beat_strb_o(beat_strb), .beat_idx_o(beat_idx),
        .beat_last_o(beat_last), .err_o(err)
    );

    // Reference model: beat n address straight from the burst-type rules.
    function automatic logic [31:0] m_addr(logic [31:0] st, int len, int sz, int bt, int n);
        longint b, a0, w, lower, s;
        s  = longint'(st);
        b  = longint'(1) << sz;
        a0 = s - (s % b);
        if (bt == 0 || n == 0) return st;
        if (bt == 2) begin
            w     = longint'(len + 1) * b;
            lower = s & ~(w - 1);
            return 32'(lower + ((a0 - lower + longint'(n) * b) % w));
        end
        return 32'(a0 + longint'(n) * b);
    endfunction

    function automatic logic [7:0] m_strb(logic [31:0] a, int sz);
        int lo, b, first;
        logic [7:0] m;
        b = 1 << sz;
        lo = int'(a % 32'd8);
        first = lo - (lo % b);
        m = 8'h00;
        for (int i = 0; i < 8; i++) m[i] = (i >= lo) && (i < first + b);
        return m;
    endfunction

    function automatic bit m_err(logic [31:0] a, int len, int sz, int bt);
        longint b, a0, lastb;
        bit e;
        b = longint'(1) << sz;
        a0 = longint'(a) - (longint'(a) % b);
        lastb = a0 + longint'(len + 1) * b - 1;
        e = (bt == 3) || (sz > 3);
        if (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
        if (bt == 2 && (longint'(a) % b) != 0) e = 1'b1;
        if (bt == 1 && (lastb / 4096) != (a0 / 4096)) e = 1'b1;
        return CHK_EN && e;
    endfunction

    // Issue one request and record every accepted beat plus handshake-timing observations.
    task automatic do_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        int cyc;
        bit done;
        logic pv, pl, r;
        logic [31:0] pa;
        logic [7:0] ps, pi;
        o_addr.delete(); o_strb.delete(); o_idx.delete(); o_last.delete(); o_id.delete();
        o_err_cnt = 0; o_hold_viol = 0; o_busy_ready = 0; o_timeout = 1'b0;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        if (req_ready !== 1'b1) begin o_timeout = 1'b1; return; end
        req_valid = 1'b1; req_id = id; req_addr = a; req_len = l; req_size = s; req_burst = b;
        @(negedge clk);
        req_valid = 1'b0; req_id = 4'($urandom); req_addr = $urandom;
        req_len = 8'($urandom); req_size = 3'($urandom); req_burst = 2'($urandom);
        o_first_valid = beat_valid; o_err_first = err;
        done = 1'b0; pv = 1'b0; pa = 32'd0; ps = 8'd0; pi = 8'd0; pl = 1'b0; cyc = 0;
        while (!done && cyc < 2000) begin
            if (err === 1'b1) o_err_cnt++;
            if (req_ready !== 1'b0) o_busy_ready++;
            if (pv && (beat_valid !== 1'b1 || beat_addr !== pa || beat_strb !== ps ||
                       beat_idx !== pi || beat_last !== pl)) o_hold_viol++;
            r = (r_pat.size() > 0) ? r_pat.pop_front() : 1'($urandom_range(99) < rdy_pct);
            beat_ready = r;
            if (beat_valid === 1'b1 && r) begin
                o_addr.push_back(beat_addr); o_strb.push_back(beat_strb);
                o_idx.push_back(beat_idx); o_last.push_back(beat_last); o_id.push_back(beat_id);
                if (beat_last === 1'b1 || o_addr.size() > 300) done = 1'b1;
            end
            pv = (beat_valid === 1'b1) && !r;
            pa = beat_addr; ps = beat_strb; pi = beat_idx; pl = beat_last;
            @(negedge clk);
            cyc++;
        end
        if (!done) o_timeout = 1'b1;
        beat_ready = 1'b0;
        o_ready_after = req_ready; o_valid_after = beat_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; beat_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (beat_valid !== 1'b0 || beat_last !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: valid=%b last=%b err=%b want 0 0 0", beat_valid, beat_last, err); end
        total++; if (beat_addr !== 32'd0 || beat_strb !== 8'd0 || beat_idx !== 8'd0 || beat_id !== 4'd0) begin
            bad++; $display("FAIL reset_data: addr=%h strb=%h idx=%0d id=%h want zeros", beat_addr, beat_strb, beat_idx, beat_id); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: ready=%b valid=%b want 1 0", req_ready, beat_valid); end
    endtask

    task automatic test_incr;
        logic [31:0] ea[4];
        logic [7:0]  es[4];
        ea = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
        es = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        rdy_pct = 100;
        do_burst(4'h5, 32'h1004, 8'd3, 3'd2, 2'b01);
        total++; if (o_timeout || o_addr.size() != 4) begin bad++; $display("FAIL incr_count: got %0d want 4", o_addr.size()); end
        total++; if (o_first_valid !== 1'b1) begin bad++; $display("FAIL incr_latency: got %b want 1", o_first_valid); end
        for (int i = 0; i < o_addr.size() && i < 4; i++) begin
            total++;
            if (o_addr[i] !== ea[i] || o_strb[i] !== es[i] || o_idx[i] !== 8'(i) ||
                o_last[i] !== (i == 3) || o_id[i] !== 4'h5) begin
                bad++; $display("FAIL incr_beat%0d: got a=%h s=%h i=%0d l=%b id=%h want a=%h s=%h l=%b id=5",
                                i, o_addr[i], o_strb[i], o_idx[i], o_last[i], o_id[i], ea[i], es[i], (i == 3));
            end
        end
        total++; if (o_ready_after !== 1'b1 || o_busy_ready != 0) begin
            bad++; $display("FAIL incr_ready: after=%b busy=%0d want 1 0", o_ready_after, o_busy_ready); end
    endtask

    task automatic test_unaligned;
        rdy_pct = 100;
        do_burst(4'h1, 32'h1006, 8'd1, 3'd2, 2'b01);
        total++; if (o_addr.size() != 2) begin bad++; $display("FAIL unal_count: got %0d want 2", o_addr.size()); end
        else begin
            total++; if (o_addr[0] !== 32'h1006 || o_strb[0] !== 8'hC0) begin
                bad++; $display("FAIL unal_beat0: got %h/%h want 00001006/c0", o_addr[0], o_strb[0]); end
            total++; if (o_addr[1] !== 32'h1008 || o_strb[1] !== 8'h0F || o_last[1] !== 1'b1) begin
                bad++; $display("FAIL unal_beat1: got %h/%h/%b want 00001008/0f/1", o_addr[1], o_strb[1], o_last[1]); end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] ea[4];
        ea = '{32'h38, 32'h20, 32'h28, 32'h30};
        rdy_pct = 100;
        do_burst(4'h2, 32'h38, 8'd3, 3'd3, 2'b10);
        total++; if (o_addr.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", o_addr.size()); end
        for (int i = 0; i < o_addr.size() && i < 4; i++) begin
            total++; if (o_addr[i] !== ea[i] || o_strb[i] !== 8'hFF) begin
                bad++; $display("FAIL wrap_beat%0d: got %h/%h want %h/ff", i, o_addr[i], o_strb[i], ea[i]); end
        end
    endtask

    task automatic test_fixed_backpressure;
        r_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_burst(4'h7, 32'h100, 8'd2, 3'd2, 2'b00);
        total++; if (o_addr.size() != 3) begin bad++; $display("FAIL fixed_count: got %0d want 3", o_addr.size()); end
        for (int i = 0; i < o_addr.size() && i < 3; i++) begin
            total++; if (o_addr[i] !== 32'h100 || o_strb[i] !== 8'h0F || o_idx[i] !== 8'(i)) begin
                bad++; $display("FAIL fixed_beat%0d: got %h/%h/%0d want 00000100/0f/%0d", i, o_addr[i], o_strb[i], o_idx[i], i); end
        end
        total++; if (o_hold_viol != 0) begin bad++; $display("FAIL fixed_hold: got %0d want 0", o_hold_viol); end
        total++; if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin
            bad++; $display("FAIL fixed_ready_after: ready=%b valid=%b want 1 0", o_ready_after, o_valid_after); end
        r_pat.delete();
    endtask

    task automatic test_reset_mid_burst;
        req_valid = 1'b1; req_id = 4'h9; req_addr = 32'h2000; req_len = 8'd7; req_size = 3'd2; req_burst = 2'b01;
        @(negedge clk);
        req_valid = 1'b0; beat_ready = 1'b1;
        @(negedge clk);
        total++; if (beat_idx !== 8'd1 || beat_valid !== 1'b1) begin
            bad++; $display("FAIL mid_idx1: got idx=%0d valid=%b want 1 1", beat_idx, beat_valid); end
        rst = 1'b1; beat_ready = 1'b0;
        @(negedge clk);
        total++; if (beat_valid !== 1'b0 || req_ready !== 1'b1 || beat_idx !== 8'd0 || beat_addr !== 32'd0) begin
            bad++; $display("FAIL mid_reset: valid=%b ready=%b idx=%0d addr=%h want 0 1 0 0", beat_valid, req_ready, beat_idx, beat_addr); end
        rst = 1'b0;
        @(negedge clk);
        rdy_pct = 100;
        do_burst(4'hA, 32'h40, 8'd1, 3'd2, 2'b01);
        total++; if (o_addr.size() != 2 || o_idx[0] !== 8'd0 || o_addr[0] !== 32'h40 || o_id[0] !== 4'hA) begin
            bad++; $display("FAIL mid_restart: got n=%0d want 2 beats starting idx 0 at 00000040", o_addr.size()); end
    endtask

    task automatic test_legality;
        bit ee;
        rdy_pct = 100;
        ee = m_err(32'hFF8, 1, 3, 1);
        do_burst(4'h3, 32'hFF8, 8'd1, 3'd3, 2'b01);
        total++; if (o_err_first !== ee || o_err_cnt != int'(ee)) begin
            bad++; $display("FAIL legal_4k_err: first=%b cnt=%0d want %b %0d", o_err_first, o_err_cnt, ee, ee); end
        total++; if (o_addr.size() != 2 || o_addr[0] !== 32'hFF8 || o_addr[1] !== 32'h1000) begin
            bad++; $display("FAIL legal_4k_beats: got n=%0d want 000000ff8,00001000", o_addr.size()); end
        ee = m_err(32'h0, 2, 2, 2);
        do_burst(4'h4, 32'h0, 8'd2, 3'd2, 2'b10);
        total++; if (o_err_first !== ee || o_err_cnt != int'(ee)) begin
            bad++; $display("FAIL legal_wrap_err: first=%b cnt=%0d want %b %0d", o_err_first, o_err_cnt, ee, ee); end
        total++; if (o_addr.size() != 3 || o_addr[2] !== 32'h8) begin
            bad++; $display("FAIL legal_wrap_beats: got n=%0d want 3 ending 00000008", o_addr.size()); end
    endtask

    task automatic test_random;
        int len, sz, bt, nb;
        logic [31:0] a, ea;
        logic [3:0]  id;
        logic [7:0]  es;
        int wl[4];
        wl = '{1, 3, 7, 15};
        rdy_pct = 60;
        for (int k = 0; k < 40; k++) begin
            sz = $urandom_range(3);
            bt = $urandom_range(3);
            len = (bt == 2) ? wl[$urandom_range(3)] : $urandom_range(15);
            a = ($urandom_range(4) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(63))) : $urandom;
            id = 4'($urandom);
            nb = len + 1;
            do_burst(id, a, 8'(len), 3'(sz), 2'(bt));
            total++; if (o_timeout || o_addr.size() != nb) begin
                bad++; $display("FAIL rand%0d_count: got %0d want %0d", k, o_addr.size(), nb); end
            for (int i = 0; i < o_addr.size() && i < nb; i++) begin
                ea = m_addr(a, len, sz, bt, i);
                es = m_strb(ea, sz);
                total++;
                if (o_addr[i] !== ea || o_strb[i] !== es || o_idx[i] !== 8'(i) ||
                    o_last[i] !== (i == nb - 1) || o_id[i] !== id) begin
                    bad++; $display("FAIL rand%0d_beat%0d: got a=%h s=%h i=%0d l=%b id=%h want a=%h s=%h l=%b id=%h",
                                    k, i, o_addr[i], o_strb[i], o_idx[i], o_last[i], o_id[i], ea, es, (i == nb - 1), id);
                end
            end
            total++; if (o_err_cnt != int'(m_err(a, len, sz, bt)) || o_hold_viol != 0) begin
                bad++; $display("FAIL rand%0d_err_hold: err=%0d hold=%0d want %0d 0", k, o_err_cnt, o_hold_viol, m_err(a, len, sz, bt)); end
            total++; if (o_ready_after !== 1'b1 || o_busy_ready != 0 || o_valid_after !== 1'b0) begin
                bad++; $display("FAIL rand%0d_handshake: after=%b busy=%0d valid=%b want 1 0 0", k, o_ready_after, o_busy_ready, o_valid_after); end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; beat_ready = 1'b0;
        req_id = 4'd0; req_addr = 32'd0; req_len = 8'd0; req_size = 3'd0; req_burst = 2'd0;
        test_reset();
        test_incr();
        test_unaligned();
        test_wrap();
        test_fixed_backpressure();
        test_reset_mid_burst();
        test_legality();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
